// File: rtl/sec60_counter.sv
// Modulo-60 counter stepped by a programmable clock-divider tick.
// Drives seconds/minutes display chains; num = 1 (or 0) turns it into a bare 0..59 counter.
module sec60_counter #(
  parameter int DIV_W = 32,
  parameter int OUT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] num,
  output logic [OUT_W-1:0] out
);

  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(59);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // num = 0 and num = 1 both tick every cycle. The num - 1 underflow at 0 is masked
  // by the first term. The >= compare recovers at once when num shrinks below div_cnt.
  always_comb begin
    tick = 1'b0;
    if (num <= DIV_ONE) begin
      tick = 1'b1;
    end else if (div_cnt >= (num - DIV_ONE)) begin
      tick = 1'b1;
    end
  end

  // rst_n is active-high here despite its name; reset overrides tick.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      out <= '0;
    end else if (tick) begin
      if (out >= OUT_MAX) begin
        out <= '0;
      end else begin
        out <= out + OUT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sec60_counter.sv
// Self-checking bench for sec60_counter.
// Each edge's expected count is queued before the edge and popped for comparison after it.
module tb_sec60_counter;

  logic        clk;
  logic        rst_n;
  logic [31:0] num;
  logic [5:0]  out;

  logic [5:0] exp_q[$];
  int checks;
  int errors;

  sec60_counter #(.DIV_W(32), .OUT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .num   (num),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the expected value, take one rising edge, then compare 1 time unit later.
  task automatic edge_check(input logic [5:0] expv, input string name);
    logic [5:0] e;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (out !== e) begin
      errors++;
      $display("FAIL %s: out=%0d expected=%0d at t=%0t", name, out, e, $time);
    end
  endtask

  task automatic hold_reset(input int cycles, input string name);
    rst_n = 1'b1;
    for (int i = 0; i < cycles; i++) edge_check(6'd0, name);
    rst_n = 1'b0;
  endtask

  // Runs edges 1..edges after release with a constant divide ratio n (n = 0 acts as 1).
  task automatic run_divided(input int n, input int edges, input string name);
    int eff;
    eff = (n <= 1) ? 1 : n;
    for (int k = 1; k <= edges; k++) edge_check(6'((k / eff) % 60), name);
  endtask

  task automatic test_reset();
    num = 32'($urandom_range(1, 20));
    hold_reset(2, "reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) edge_check(6'd0, "reset_stays_zero");
    rst_n = 1'b0;
  endtask

  task automatic test_bare();
    num = 32'd1;
    hold_reset(2, "bare_reset");
    for (int k = 1; k <= 62; k++) edge_check(6'(k % 60), "bare_count");
  endtask

  task automatic test_divided();
    num = 32'd4;
    hold_reset(2, "div4_reset");
    run_divided(4, 244, "div4_count");
  endtask

  task automatic test_num_change();
    num = 32'd10;
    hold_reset(2, "chg_reset");
    for (int k = 1; k <= 7; k++) edge_check(6'd0, "chg_before");
    // div_cnt is 7 here; shrinking num to 3 forces a tick on the very next edge.
    num = 32'd3;
    for (int j = 0; j <= 10; j++) edge_check(6'(1 + j / 3), "chg_after");
  endtask

  task automatic test_num_zero();
    num = 32'd0;
    hold_reset(2, "zero_reset");
    for (int k = 1; k <= 62; k++) edge_check(6'(k % 60), "zero_count");
  endtask

  task automatic test_reset_mid();
    num = 32'd5;
    hold_reset(1, "mid_reset_init");
    run_divided(5, 187, "mid_pre");
    // Edge 187 left out = 37 and div_cnt = 2; reset lands mid-step.
    hold_reset(1, "mid_reset_edge");
    for (int k = 1; k <= 4; k++) edge_check(6'd0, "mid_restart_wait");
    edge_check(6'd1, "mid_restart_first");
    for (int k = 6; k <= 12; k++) edge_check(6'(k / 5), "mid_restart_more");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(2, 7);
      num = 32'(n);
      hold_reset(1, "rand_reset");
      run_divided(n, 62 * n, "rand_count");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    num    = 32'd1;
    @(posedge clk);
    #1;
    test_reset();
    test_bare();
    test_divided();
    test_num_change();
    test_num_zero();
    test_reset_mid();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: left=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sec60_counter.md
# sec60_counter

Free-running modulo-60 counter advanced by a programmable clock-divider tick, for seconds/minutes display chains. A 32-bit divider counts system clocks up to a runtime-selectable terminal value `num` and emits a one-cycle enable. A 6-bit counter steps 0..59 on each enable. With `num` = 50 000 000 and a 50 MHz `clk`, `out` advances once per second. With `num` = 1, `out` advances every clock, which is the bare 0..59 counter mode.

## Interface
- `DIV_W`, 32: width of `num` and of the internal divider counter.
- `OUT_W`, 6: width of `out`; fixed at 6 for the 0..59 range.
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset.
  - Synchronous and active-high: `rst_n` = 1 at a rising edge resets the block.
  - The `_n` suffix is the codebase port name only; it does not mean active-low.
- `num`, input, `DIV_W`: divide ratio, i.e. clocks per `out` step. Sampled every cycle; no handshake.
- `out`, output, `OUT_W`: current count, 0..59, registered.

## Operation
- Divider register `div_cnt` (`DIV_W` bits).
  - Tick is combinational: `tick` = (`num` <= 1) or (`div_cnt` >= `num` - 1).
  - On `tick`, `div_cnt` becomes 0; otherwise `div_cnt` becomes `div_cnt` + 1.
- Count register `out`.
  - On `tick`: if `out` == 59, `out` becomes 0; otherwise `out` becomes `out` + 1.
  - Without `tick`, `out` holds.
- Reset (`rst_n` = 1 at an edge) sets `div_cnt` = 0 and `out` = 0. Reset overrides `tick`.
- `num` = 0 behaves exactly like `num` = 1 (tick every cycle, no divide-by-zero hazard).
- `num` changed mid-count:
  - The new value takes effect on the next compare.
  - The `>=` compare handles a new `num` below the current `div_cnt`: tick fires on the next cycle, then counting restarts from 0.
  - `div_cnt` never runs past `num` - 1 by more than one cycle and never wraps through 2^32.
- `out` never takes values 60..63.
- No arithmetic overflow on `out`: the wrap happens at 59.

## Timing
- Edge numbering: edge 1 is the first rising edge with `rst_n` = 0 after reset.
- At edge k, `div_cnt` = k mod `num`.
- `out` increments at edges `num`, 2·`num`, 3·`num`, … after reset release.
  - The increment happens on the same edge that `div_cnt` returns to 0.
  - Latency from reset release to the first `out` change is exactly `num` clocks.
- The `out` period is `num` clocks per step, i.e. 60·`num` clocks per full 0..59 cycle.
- Reset asserted mid-operation:
  - `out` = 0 and `div_cnt` = 0 at that edge.
  - Counting resumes from scratch one edge after release.
- `out` changes only on rising edges; it is glitch-free as a direct register output.

## Test plan
- Reset: hold `rst_n` = 1 for 2 cycles with any `num` -> `out` = 0 and `div_cnt` = 0; `out` stays 0 while reset is held.
- Bare counter, `num` = 1: release reset -> `out` = 1, 2, … 59, 0, 1 on consecutive edges; wrap at edge 60.
- Divided count, `num` = 4: release reset -> `out` = 0 on edges 1–3 and 1 on edge 4; `out` = 59 at edge 236 and 0 at edge 240.
- Runtime `num` change: `num` = 10; at `div_cnt` = 7, change `num` to 3 -> tick on the next edge, `out` +1, then further steps every 3 clocks.
- `num` = 0: release reset -> identical sequence to `num` = 1.
- Reset mid-count: `num` = 5, assert reset when `out` = 37 -> `out` = 0 at that edge; after release, first step to 1 occurs 5 edges later.
